// File: rtl/fft_config_scheduler_pkg.sv
// Shared types and bit positions for the FFT core time-sharing scheduler.
package fft_config_scheduler_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCfg,
      StRun
   } state_e;

   localparam int unsigned FWD_INV_BIT = 0;
   localparam int unsigned SCALE_LSB   = 1;

endpackage

// File: rtl/fft_config_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational winner, registered last-served owner.
module fft_config_scheduler_rr_arbiter_2 (
   input  logic aclk_i,
   input  logic areset_i,
   input  logic req_fwd_i,
   input  logic req_inv_i,
   input  logic update_i,
   output logic gnt_fwd_o,
   output logic last_fwd_o
);

   logic last_fwd_q, last_fwd_d;

   // On contention the side that was not served last wins.
   always_comb begin
      gnt_fwd_o = 1'b0;
      if (req_fwd_i && req_inv_i) begin
         gnt_fwd_o = ~last_fwd_q;
      end else if (req_fwd_i) begin
         gnt_fwd_o = 1'b1;
      end
   end

   always_comb begin
      last_fwd_d = last_fwd_q;
      if (update_i) begin
         last_fwd_d = gnt_fwd_o;
      end
   end

   always_ff @(posedge aclk_i) begin
      if (areset_i) begin
         last_fwd_q <= 1'b0;
      end else begin
         last_fwd_q <= last_fwd_d;
      end
   end

   assign last_fwd_o = last_fwd_q;

endmodule

// File: rtl/fft_config_scheduler.sv
// Time-shares one FFT core between forward and inverse requesters: arbitrate, send one
// config word, grant the datapath until frame completion or watchdog expiry.
module fft_config_scheduler
   import fft_config_scheduler_pkg::*;
#(
   parameter int unsigned                 CFG_WIDTH    = 24,
   parameter int unsigned                 STATUS_WIDTH = 24,
   parameter logic        [CFG_WIDTH-2:0] SCALE_FWD    = 23'h0AAA,
   parameter logic        [CFG_WIDTH-2:0] SCALE_INV    = 23'h0555,
   parameter int unsigned                 TIMEOUT      = 4096
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    req_fwd,
   input  logic                    req_inv,
   output logic                    grant_fwd,
   output logic                    grant_inv,
   output logic [CFG_WIDTH-1:0]    m_axis_config_tdata,
   output logic                    m_axis_config_tvalid,
   input  logic                    m_axis_config_tready,
   input  logic [STATUS_WIDTH-1:0] s_axis_status_tdata,
   input  logic                    s_axis_status_tvalid,
   output logic                    s_axis_status_tready,
   input  logic                    frame_done,
   output logic [STATUS_WIDTH-1:0] status_data,
   output logic                    status_valid,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [15:0]             frame_count
);

   localparam int unsigned WdW    = $clog2(TIMEOUT);
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

   state_e                  state_q, state_d;
   logic [WdW-1:0]          wdog_q, wdog_d;
   logic [15:0]             frame_count_q, frame_count_d;
   logic                    timeout_err_q, timeout_err_d;
   logic [STATUS_WIDTH-1:0] status_data_q, status_data_d;
   logic                    status_valid_q, status_valid_d;
   logic                    arb_update;
   logic                    arb_gnt_fwd;
   logic                    owner_fwd;

   // owner_fwd is the last-served side, which is the current owner in CFG and RUN.
   fft_config_scheduler_rr_arbiter_2 u_arb (
      .aclk_i     (aclk),
      .areset_i   (areset),
      .req_fwd_i  (req_fwd),
      .req_inv_i  (req_inv),
      .update_i   (arb_update),
      .gnt_fwd_o  (arb_gnt_fwd),
      .last_fwd_o (owner_fwd)
   );

   always_comb begin
      state_d       = state_q;
      wdog_d        = wdog_q;
      frame_count_d = frame_count_q;
      timeout_err_d = timeout_err_q;
      arb_update    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_fwd || req_inv) begin
               state_d    = StCfg;
               arb_update = 1'b1;
            end
         end
         StCfg: begin
            if (m_axis_config_tready) begin
               state_d = StRun;
               wdog_d  = '0;
            end
         end
         StRun: begin
            if (frame_done) begin
               state_d       = StIdle;
               frame_count_d = frame_count_q + 16'd1;
            end else if (wdog_q == WdLast) begin
               state_d       = StIdle;
               timeout_err_d = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      status_data_d  = status_data_q;
      status_valid_d = s_axis_status_tvalid;
      if (s_axis_status_tvalid) begin
         status_data_d = s_axis_status_tdata;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q        <= StIdle;
         wdog_q         <= '0;
         frame_count_q  <= '0;
         timeout_err_q  <= 1'b0;
         status_data_q  <= '0;
         status_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wdog_q         <= wdog_d;
         frame_count_q  <= frame_count_d;
         timeout_err_q  <= timeout_err_d;
         status_data_q  <= status_data_d;
         status_valid_q <= status_valid_d;
      end
   end

   always_comb begin
      m_axis_config_tdata = '0;
      if (state_q == StCfg) begin
         m_axis_config_tdata[CFG_WIDTH-1:SCALE_LSB] = owner_fwd ? SCALE_FWD : SCALE_INV;
         m_axis_config_tdata[FWD_INV_BIT]           = owner_fwd;
      end
   end

   assign m_axis_config_tvalid = (state_q == StCfg);
   assign grant_fwd            = (state_q == StRun) && owner_fwd;
   assign grant_inv            = (state_q == StRun) && !owner_fwd;
   assign busy                 = (state_q != StIdle);
   assign s_axis_status_tready = 1'b1;
   assign status_data          = status_data_q;
   assign status_valid         = status_valid_q;
   assign timeout_err          = timeout_err_q;
   assign frame_count          = frame_count_q;

endmodule

// File: tb/tb_fft_config_scheduler.sv
// Directed bench for fft_config_scheduler with a short watchdog.
module tb_fft_config_scheduler;

   logic        aclk = 1'b0;
   logic        areset;
   logic        req_fwd, req_inv;
   logic        grant_fwd, grant_inv;
   logic [23:0] cfg_tdata;
   logic        cfg_tvalid, cfg_tready;
   logic [23:0] st_tdata;
   logic        st_tvalid, st_tready;
   logic        frame_done;
   logic [23:0] status_data;
   logic        status_valid, busy, timeout_err;
   logic [15:0] frame_count;

   int checks = 0;
   int passes = 0;

   fft_config_scheduler #(
      .TIMEOUT (16)
   ) dut (
      .aclk                 (aclk),
      .areset               (areset),
      .req_fwd              (req_fwd),
      .req_inv              (req_inv),
      .grant_fwd            (grant_fwd),
      .grant_inv            (grant_inv),
      .m_axis_config_tdata  (cfg_tdata),
      .m_axis_config_tvalid (cfg_tvalid),
      .m_axis_config_tready (cfg_tready),
      .s_axis_status_tdata  (st_tdata),
      .s_axis_status_tvalid (st_tvalid),
      .s_axis_status_tready (st_tready),
      .frame_done           (frame_done),
      .status_data          (status_data),
      .status_valid         (status_valid),
      .busy                 (busy),
      .timeout_err          (timeout_err),
      .frame_count          (frame_count)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      tick();
      tick();
      areset = 1'b0;
   endtask

   task automatic test_reset();
      req_fwd = 0; req_inv = 0; cfg_tready = 0; st_tdata = '0; st_tvalid = 0;
      frame_done = 0;
      do_reset();
      checks++;
      if ({cfg_tvalid, grant_fwd, grant_inv, busy, timeout_err, status_valid} !== 6'b0)
         $display("FAIL reset_ctrl got %b want 000000",
                  {cfg_tvalid, grant_fwd, grant_inv, busy, timeout_err, status_valid});
      else passes++;
      checks++;
      if (st_tready !== 1'b1) $display("FAIL reset_tready got %b want 1", st_tready);
      else passes++;
      checks++;
      if (frame_count !== 16'd0 || cfg_tdata !== 24'd0 || status_data !== 24'd0)
         $display("FAIL reset_data got cnt=%h tdata=%h sd=%h want 0", frame_count, cfg_tdata,
                  status_data);
      else passes++;
   endtask

   task automatic test_single_fwd();
      req_fwd = 1; cfg_tready = 1;
      tick();
      req_fwd = 0;
      checks++;
      if (cfg_tvalid !== 1'b1 || cfg_tdata !== 24'h001555 || busy !== 1'b1)
         $display("FAIL single_cfg got v=%b d=%h b=%b want 1 001555 1", cfg_tvalid, cfg_tdata,
                  busy);
      else passes++;
      tick();
      checks++;
      if (cfg_tvalid !== 1'b0 || grant_fwd !== 1'b1 || grant_inv !== 1'b0)
         $display("FAIL single_grant got v=%b gf=%b gi=%b want 0 1 0", cfg_tvalid, grant_fwd,
                  grant_inv);
      else passes++;
      frame_done = 1;
      tick();
      frame_done = 0;
      checks++;
      if (grant_fwd !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd1)
         $display("FAIL single_done got gf=%b b=%b cnt=%0d want 0 0 1", grant_fwd, busy,
                  frame_count);
      else passes++;
   endtask

   task automatic test_alternate();
      logic exp_fwd;
      do_reset();
      req_fwd = 1; req_inv = 1; cfg_tready = 1;
      exp_fwd = 1'b1;
      for (int f = 0; f < 4; f++) begin
         tick();
         checks++;
         if (cfg_tvalid !== 1'b1 || cfg_tdata[0] !== exp_fwd)
            $display("FAIL alt_cfg%0d got v=%b lsb=%b want 1 %b", f, cfg_tvalid, cfg_tdata[0],
                     exp_fwd);
         else passes++;
         tick();
         checks++;
         if (grant_fwd !== exp_fwd || grant_inv !== !exp_fwd)
            $display("FAIL alt_grant%0d got gf=%b gi=%b want %b %b", f, grant_fwd, grant_inv,
                     exp_fwd, !exp_fwd);
         else passes++;
         frame_done = 1;
         tick();
         frame_done = 0;
         exp_fwd = !exp_fwd;
      end
      req_fwd = 0; req_inv = 0;
      checks++;
      if (frame_count !== 16'd4) $display("FAIL alt_count got %0d want 4", frame_count);
      else passes++;
   endtask

   task automatic test_backpressure();
      do_reset();
      cfg_tready = 0; req_inv = 1;
      tick();
      req_inv = 0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cfg_tvalid !== 1'b1 || cfg_tdata !== 24'h000AAA || grant_inv !== 1'b0)
            $display("FAIL bp_hold%0d got v=%b d=%h gi=%b want 1 000aaa 0", i, cfg_tvalid,
                     cfg_tdata, grant_inv);
         else passes++;
         tick();
      end
      cfg_tready = 1;
      tick();
      checks++;
      if (grant_inv !== 1'b1 || grant_fwd !== 1'b0 || cfg_tvalid !== 1'b0)
         $display("FAIL bp_grant got gi=%b gf=%b v=%b want 1 0 0", grant_inv, grant_fwd,
                  cfg_tvalid);
      else passes++;
      frame_done = 1;
      tick();
      frame_done = 0;
   endtask

   task automatic test_timeout();
      do_reset();
      req_fwd = 1; cfg_tready = 1;
      tick();
      req_fwd = 0;
      tick();
      for (int i = 1; i < 16; i++) tick();
      checks++;
      if (grant_fwd !== 1'b1 || busy !== 1'b1 || timeout_err !== 1'b0)
         $display("FAIL to_last_run got gf=%b b=%b err=%b want 1 1 0", grant_fwd, busy,
                  timeout_err);
      else passes++;
      tick();
      checks++;
      if (grant_fwd !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b1 || frame_count !== 0)
         $display("FAIL to_expire got gf=%b b=%b err=%b cnt=%0d want 0 0 1 0", grant_fwd,
                  busy, timeout_err, frame_count);
      else passes++;
      frame_done = 1;
      tick();
      frame_done = 0;
      checks++;
      if (frame_count !== 16'd0 || busy !== 1'b0)
         $display("FAIL idle_done got cnt=%0d b=%b want 0 0", frame_count, busy);
      else passes++;
      req_inv = 1;
      tick();
      req_inv = 0;
      tick();
      frame_done = 1;
      tick();
      frame_done = 0;
      checks++;
      if (timeout_err !== 1'b1 || frame_count !== 16'd1)
         $display("FAIL to_sticky got err=%b cnt=%0d want 1 1", timeout_err, frame_count);
      else passes++;
   endtask

   task automatic test_status();
      st_tvalid = 1; st_tdata = 24'hABCDEF;
      tick();
      st_tdata = 24'h123456;
      checks++;
      if (status_valid !== 1'b1 || status_data !== 24'hABCDEF)
         $display("FAIL st_beat0 got v=%b d=%h want 1 abcdef", status_valid, status_data);
      else passes++;
      tick();
      st_tvalid = 0; st_tdata = 24'h0;
      checks++;
      if (status_valid !== 1'b1 || status_data !== 24'h123456)
         $display("FAIL st_beat1 got v=%b d=%h want 1 123456", status_valid, status_data);
      else passes++;
      tick();
      checks++;
      if (status_valid !== 1'b0 || status_data !== 24'h123456)
         $display("FAIL st_hold got v=%b d=%h want 0 123456", status_valid, status_data);
      else passes++;
   endtask

   task automatic test_areset();
      do_reset();
      req_fwd = 1; cfg_tready = 1;
      tick();
      tick();
      frame_done = 1;
      tick();
      frame_done = 0; cfg_tready = 0;
      tick();
      areset = 1;
      tick();
      areset = 0; req_fwd = 0;
      checks++;
      if (cfg_tvalid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0 || grant_fwd !== 1'b0)
         $display("FAIL rst_cfg got v=%b b=%b cnt=%0d gf=%b want 0 0 0 0", cfg_tvalid, busy,
                  frame_count, grant_fwd);
      else passes++;
      req_fwd = 1; cfg_tready = 1;
      tick();
      req_fwd = 0;
      tick();
      areset = 1;
      tick();
      areset = 0;
      checks++;
      if (grant_fwd !== 1'b0 || grant_inv !== 1'b0 || busy !== 1'b0 || cfg_tvalid !== 1'b0)
         $display("FAIL rst_run got gf=%b gi=%b b=%b v=%b want 0 0 0 0", grant_fwd, grant_inv,
                  busy, cfg_tvalid);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_single_fwd();
      test_alternate();
      test_backpressure();
      test_timeout();
      test_status();
      test_areset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
